// File: rtl/portb_input_ctrl_if.sv
// PORTB input controller bus: pin/config/strobe inputs and
// synchronized data plus interrupt flag outputs.
interface portb_input_ctrl_if;
    logic [7:0] pin_in;
    logic [7:0] trisb;
    logic       intedg;
    logic       rd_portb;
    logic       rbif_clr;
    logic       intf_clr;
    logic [7:0] portb_data;
    logic       rbif;
    logic       intf;
    logic       ready;

    modport master (
        output pin_in,
        output trisb,
        output intedg,
        output rd_portb,
        output rbif_clr,
        output intf_clr,
        input  portb_data,
        input  rbif,
        input  intf,
        input  ready
    );

    modport slave (
        input  pin_in,
        input  trisb,
        input  intedg,
        input  rd_portb,
        input  rbif_clr,
        input  intf_clr,
        output portb_data,
        output rbif,
        output intf,
        output ready
    );
endinterface

// File: rtl/portb_input_ctrl.sv
// PORTB input path: 2-flop pin synchronizer, RB7:RB4 change
// interrupt, RB0/INT edge interrupt and a short warm-up sequence.
module portb_input_ctrl (
    input  logic                 clk,
    input  logic                 rst,
    portb_input_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        WARM0 = 2'd0,
        WARM1 = 2'd1,
        WARM2 = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sync1_q, sync1_d;
    logic [7:0] sync2_q, sync2_d;
    logic [3:0] old_latch_q, old_latch_d;
    logic       prev_rb0_q, prev_rb0_d;
    logic       rbif_q, rbif_d;
    logic       intf_q, intf_d;
    logic       ready_q, ready_d;

    logic [7:0] diff;
    logic       mismatch;
    logic       edge_hit;
    logic       run;

    // Change detect on input-configured upper bits only; the low nibble
    // of the mask is zero so RB3:RB0 never contribute.
    always_comb begin
        diff     = bus.trisb & {sync2_q[7:4] ^ old_latch_q, 4'h0};
        mismatch = |diff;
        edge_hit = bus.intedg ? (!prev_rb0_q &&  sync2_q[0])
                              : ( prev_rb0_q && !sync2_q[0]);
        run      = (state_q == RUN);
    end

    // Next-state logic: warm-up sequencing, latch updates, sticky flags
    // where a set in the same cycle overrides a clear.
    always_comb begin
        state_d     = state_q;
        sync1_d     = bus.pin_in;
        sync2_d     = sync1_q;
        old_latch_d = old_latch_q;
        prev_rb0_d  = sync2_q[0];
        rbif_d      = rbif_q;
        intf_d      = intf_q;

        unique case (state_q)
            WARM0: state_d = WARM1;
            WARM1: state_d = WARM2;
            WARM2: begin
                state_d     = RUN;
                old_latch_d = sync2_q[7:4];
            end
            RUN: begin
                state_d = RUN;
                if (bus.rd_portb) old_latch_d = sync2_q[7:4];
            end
            default: state_d = WARM0;
        endcase

        if (bus.rbif_clr) rbif_d = 1'b0;
        if (run && mismatch) rbif_d = 1'b1;

        if (bus.intf_clr) intf_d = 1'b0;
        if (run && edge_hit) intf_d = 1'b1;

        ready_d = (state_d == RUN);
    end

    // State and output registers, all cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WARM0;
            sync1_q     <= 8'h00;
            sync2_q     <= 8'h00;
            old_latch_q <= 4'h0;
            prev_rb0_q  <= 1'b0;
            rbif_q      <= 1'b0;
            intf_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            old_latch_q <= old_latch_d;
            prev_rb0_q  <= prev_rb0_d;
            rbif_q      <= rbif_d;
            intf_q      <= intf_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.portb_data = sync2_q;
    assign bus.rbif       = rbif_q;
    assign bus.intf       = intf_q;
    assign bus.ready      = ready_q;

endmodule

// File: tb/tb_portb_input_ctrl.sv
// Directed bench for portb_input_ctrl: expected outputs are queued
// with each stimulus step and popped when the DUT is sampled.
module tb_portb_input_ctrl;

    typedef struct packed {
        logic [7:0] pd;
        logic       rbif;
        logic       intf;
        logic       ready;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    exp_t  exp_q[$];
    string tag_q[$];

    portb_input_ctrl_if bus ();

    portb_input_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "timeout");
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [7:0] pd,
                        input logic rb, input logic inf,
                        input logic rdy);
        exp_t e;
        e.pd    = pd;
        e.rbif  = rb;
        e.intf  = inf;
        e.ready = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic cmp1(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        cmp1({t, ".portb_data"}, bus.portb_data, e.pd);
        cmp1({t, ".rbif"}, {7'h0, bus.rbif}, {7'h0, e.rbif});
        cmp1({t, ".intf"}, {7'h0, bus.intf}, {7'h0, e.intf});
        cmp1({t, ".ready"}, {7'h0, bus.ready}, {7'h0, e.ready});
    endtask

    task automatic expect_now(input string tag, input logic [7:0] pd,
                              input logic rb, input logic inf,
                              input logic rdy);
        push(tag, pd, rb, inf, rdy);
        check();
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst             = 1'b1;
        bus.pin_in      = 8'hFF;
        bus.trisb       = 8'hFF;
        bus.intedg      = 1'b1;
        bus.rd_portb    = 1'b0;
        bus.rbif_clr    = 1'b0;
        bus.intf_clr    = 1'b0;

        // power-up with all pins high
        #12;
        expect_now("reset", 8'h00, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        clk_n(1);
        expect_now("pu_clk1", 8'h00, 0, 0, 0);
        clk_n(1);
        expect_now("pu_clk2", 8'hFF, 0, 0, 0);
        clk_n(1);
        expect_now("pu_clk3", 8'hFF, 0, 0, 1);
        clk_n(3);
        expect_now("pu_idle", 8'hFF, 0, 0, 1);

        // bring old_latch to 0 with RB7:RB4 inputs
        bus.trisb  = 8'hF0;
        bus.pin_in = 8'h00;
        clk_n(3);
        expect_now("drop_set", 8'h00, 1, 0, 1);
        bus.rd_portb = 1'b1;
        clk_n(1);
        bus.rd_portb = 1'b0;
        bus.rbif_clr = 1'b1;
        clk_n(1);
        bus.rbif_clr = 1'b0;
        expect_now("drop_clr", 8'h00, 0, 0, 1);

        // change interrupt on RB5
        bus.pin_in = 8'h20;
        clk_n(2);
        expect_now("rb5_pre", 8'h20, 0, 0, 1);
        clk_n(1);
        expect_now("rb5_set", 8'h20, 1, 0, 1);
        bus.rd_portb = 1'b1;
        clk_n(1);
        bus.rd_portb = 1'b0;
        expect_now("rb5_read", 8'h20, 1, 0, 1);
        bus.rbif_clr = 1'b1;
        clk_n(1);
        bus.rbif_clr = 1'b0;
        expect_now("rb5_clr", 8'h20, 0, 0, 1);
        clk_n(3);
        expect_now("rb5_stay", 8'h20, 0, 0, 1);

        // output-configured upper bits do not flag
        bus.trisb  = 8'h0F;
        bus.pin_in = 8'hF0;
        clk_n(3);
        expect_now("mask_f0", 8'hF0, 0, 0, 1);
        bus.pin_in = 8'h50;
        clk_n(3);
        expect_now("mask_50", 8'h50, 0, 0, 1);
        bus.pin_in = 8'h00;
        clk_n(3);
        expect_now("mask_00", 8'h00, 0, 0, 1);

        // RB0 edges with trisb[0] = 0
        bus.trisb  = 8'h00;
        bus.pin_in = 8'h01;
        clk_n(3);
        expect_now("rise", 8'h01, 0, 1, 1);
        bus.intf_clr = 1'b1;
        clk_n(1);
        bus.intf_clr = 1'b0;
        expect_now("rise_clr", 8'h01, 0, 0, 1);
        bus.intedg = 1'b0;
        clk_n(2);
        expect_now("edg_tog0", 8'h01, 0, 0, 1);
        bus.pin_in = 8'h00;
        clk_n(3);
        expect_now("fall", 8'h00, 0, 1, 1);
        bus.intf_clr = 1'b1;
        clk_n(1);
        bus.intf_clr = 1'b0;
        expect_now("fall_clr", 8'h00, 0, 0, 1);
        bus.intedg = 1'b1;
        clk_n(2);
        expect_now("edg_tog1", 8'h00, 0, 0, 1);
        bus.intedg = 1'b0;
        clk_n(2);
        expect_now("edg_tog2", 8'h00, 0, 0, 1);

        // intf_clr in the same cycle as the edge term
        bus.intedg = 1'b1;
        clk_n(1);
        bus.pin_in = 8'h01;
        clk_n(2);
        bus.intf_clr = 1'b1;
        clk_n(1);
        bus.intf_clr = 1'b0;
        expect_now("intf_coll", 8'h01, 0, 1, 1);

        // rbif_clr plus rd_portb while mismatch is true
        bus.trisb  = 8'hF0;
        bus.pin_in = 8'h11;
        clk_n(2);
        bus.rbif_clr = 1'b1;
        bus.rd_portb = 1'b1;
        clk_n(1);
        bus.rbif_clr = 1'b0;
        bus.rd_portb = 1'b0;
        expect_now("rbif_coll", 8'h11, 1, 1, 1);
        clk_n(2);
        expect_now("rbif_hold", 8'h11, 1, 1, 1);

        // asynchronous reset mid-run
        #3;
        rst = 1'b1;
        #1;
        expect_now("mid_rst", 8'h00, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        clk_n(2);
        expect_now("rel_clk2", 8'h11, 0, 0, 0);
        clk_n(1);
        expect_now("rel_clk3", 8'h11, 0, 0, 1);
        clk_n(4);
        expect_now("rel_idle", 8'h11, 0, 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
